inside_lookup_ring: RTL and testbench

//  Parametrised ring buffer with parallel set-membership ("inside") lookup. Stores the last

---
 rtl/inside_lookup_ring_pkg.sv | 32 +++
 rtl/inside_match_unit.sv | 28 ++
 rtl/inside_lookup_ring.sv | 146 ++++++++++++++
 tb/tb_inside_lookup_ring.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/inside_lookup_ring_pkg.sv
// Shared sizing helpers and priority-encode function for the inside lookup ring.
package inside_lookup_pkg;

  // Widest bitmap lowest_set_idx accepts; DEPTH must not exceed this.
  localparam int unsigned MAX_SLOTS = 256;

  // Slot-index width for a power-of-two depth.
  function automatic int unsigned idx_bits(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Occupancy width: must hold 0..depth inclusive.
  function automatic int unsigned occ_bits(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Position of the lowest set bit; 0 when the bitmap is empty.
  function automatic int unsigned lowest_set_idx(input logic [MAX_SLOTS-1:0] bitmap);
    int unsigned idx;
    logic        found;
    idx   = 0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_SLOTS; i++) begin
      if (bitmap[i] && !found) begin
        idx   = i;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/inside_match_unit.sv
// Combinational membership test of one query value against all valid slots.
module inside_match_unit
  import inside_lookup_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic [WIDTH-1:0]       q_i,
  input  logic [DEPTH*WIDTH-1:0] mem_i,
  input  logic [DEPTH-1:0]       valid_i,
  output logic                   hit_o,
  output logic [IDX_W-1:0]       idx_o
);

  logic [DEPTH-1:0] match;

  // Per-slot compare, masked by valid so unwritten slots never match.
  always_comb begin
    match = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      match[s] = valid_i[s] && (mem_i[s*WIDTH +: WIDTH] == q_i);
    end
    hit_o = |match;
    idx_o = IDX_W'(lowest_set_idx(MAX_SLOTS'(match)));
  end

endmodule

// File: rtl/inside_lookup_ring.sv
// Ring buffer of the last DEPTH writes with NUM_Q registered membership lookups.
module inside_lookup_ring
  import inside_lookup_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NUM_Q = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          wr_valid,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic [NUM_Q-1:0]              q_valid,
  input  logic [NUM_Q*WIDTH-1:0]        q_data,
  output logic [NUM_Q-1:0]              r_valid,
  output logic [NUM_Q-1:0]              r_hit,
  output logic [NUM_Q*idx_bits(DEPTH)-1:0] r_idx,
  output logic [WIDTH-1:0]              last_data,
  output logic [occ_bits(DEPTH)-1:0]    occupancy,
  output logic [CNT_W-1:0]              wr_count
);

  localparam int unsigned IDX_W = idx_bits(DEPTH);
  localparam int unsigned OCC_W = occ_bits(DEPTH);

  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [DEPTH*WIDTH-1:0] mem_flat;
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [IDX_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]       last_q, last_d;
  logic                   do_write;

  logic [NUM_Q-1:0]       m_hit;
  logic [NUM_Q*IDX_W-1:0] m_idx;
  logic [NUM_Q-1:0]       r_valid_q;
  logic [NUM_Q-1:0]       r_hit_q, r_hit_d;
  logic [NUM_Q*IDX_W-1:0] r_idx_q, r_idx_d;

  // clear wins over a same-cycle write: the write is dropped entirely.
  assign do_write = wr_valid && !clear;

  // Flatten storage for the match units (they see pre-update contents).
  always_comb begin
    mem_flat = '0;
    for (int unsigned s = 0; s < DEPTH; s++) begin
      mem_flat[s*WIDTH +: WIDTH] = mem_q[s];
    end
  end

  // Next-state for pointer, valid bitmap, occupancy and counters.
  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    if (clear) begin
      valid_d  = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else if (wr_valid) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + IDX_W'(1);
      cnt_d             = cnt_q + CNT_W'(1);
      last_d            = wr_data;
      if (occ_q != OCC_W'(DEPTH)) begin
        occ_d = occ_q + OCC_W'(1);
      end
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

  // Storage array; not reset, stale contents are masked by valid_q.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  for (genvar c = 0; c < NUM_Q; c++) begin : g_match
    inside_match_unit #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .IDX_W(IDX_W)
    ) u_match (
      .q_i    (q_data[c*WIDTH +: WIDTH]),
      .mem_i  (mem_flat),
      .valid_i(valid_q),
      .hit_o  (m_hit[c]),
      .idx_o  (m_idx[c*IDX_W +: IDX_W])
    );
  end

  // Result capture: channels without a query hold their last hit/index.
  always_comb begin
    r_hit_d = r_hit_q;
    r_idx_d = r_idx_q;
    for (int unsigned c = 0; c < NUM_Q; c++) begin
      if (q_valid[c]) begin
        r_hit_d[c]                = m_hit[c];
        r_idx_d[c*IDX_W +: IDX_W] = m_idx[c*IDX_W +: IDX_W];
      end
    end
  end

  // Result registers; reset discards any query in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_q <= '0;
      r_hit_q   <= '0;
      r_idx_q   <= '0;
    end else begin
      r_valid_q <= q_valid;
      r_hit_q   <= r_hit_d;
      r_idx_q   <= r_idx_d;
    end
  end

  assign r_valid   = r_valid_q;
  assign r_hit     = r_hit_q;
  assign r_idx     = r_idx_q;
  assign last_data = last_q;
  assign occupancy = occ_q;
  assign wr_count  = cnt_q;

endmodule

// File: tb/tb_inside_lookup_ring.sv
// Directed bench for inside_lookup_ring at default parameters.
module tb_inside_lookup_ring;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic [1:0]  q_valid;
  logic [15:0] q_data;
  logic [1:0]  r_valid;
  logic [1:0]  r_hit;
  logic [7:0]  r_idx;
  logic [7:0]  last_data;
  logic [4:0]  occupancy;
  logic [7:0]  wr_count;

  int unsigned n_cmp;
  int unsigned n_err;

  inside_lookup_ring #(
    .WIDTH(8),
    .DEPTH(16),
    .NUM_Q(2),
    .CNT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .q_valid  (q_valid),
    .q_data   (q_data),
    .r_valid  (r_valid),
    .r_hit    (r_hit),
    .r_idx    (r_idx),
    .last_data(last_data),
    .occupancy(occupancy),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] v);
    wr_valid = 1'b1;
    wr_data  = v;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic do_query(input logic [7:0] a, input logic [7:0] b);
    q_valid = 2'b11;
    q_data  = {b, a};
    step();
    q_valid = 2'b00;
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    clear    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    q_valid  = '0;
    q_data   = '0;
    step();
    step();
    rst = 1'b0;

    chk_eq("rst_rvalid", 32'(r_valid), 32'h0);
    chk_eq("rst_rhit",   32'(r_hit),   32'h0);
    chk_eq("rst_ridx",   32'(r_idx),   32'h0);
    chk_eq("rst_occ",    32'(occupancy), 32'd0);
    chk_eq("rst_cnt",    32'(wr_count),  32'd0);
    chk_eq("rst_last",   32'(last_data), 32'd0);

    // Unwritten slots never match, even for value 0.
    do_query(8'd0, 8'd0);
    chk_eq("empty_rvalid", 32'(r_valid), 32'h3);
    chk_eq("empty_rhit",   32'(r_hit),   32'h0);

    // Basic: slots 0..7 hold 0,5,..,35.
    do_reset();
    for (int unsigned i = 0; i < 8; i++) do_write(8'(i * 5));
    do_query(8'd15, 8'd20);
    chk_eq("basic_rhit", 32'(r_hit), 32'h3);
    chk_eq("basic_idx0", 32'(r_idx[3:0]), 32'd3);
    chk_eq("basic_idx1", 32'(r_idx[7:4]), 32'd4);
    chk_eq("basic_occ",  32'(occupancy), 32'd8);
    chk_eq("basic_last", 32'(last_data), 32'd35);
    chk_eq("basic_cnt",  32'(wr_count),  32'd8);

    // Single-channel query: ch1 holds its previous hit/index.
    q_valid = 2'b01;
    q_data  = {8'd0, 8'd99};
    step();
    q_valid = 2'b00;
    chk_eq("hold_rvalid", 32'(r_valid), 32'h1);
    chk_eq("hold_rhit",   32'(r_hit),   32'h2);
    chk_eq("hold_ridx",   32'(r_idx),   32'h40);

    // Overwrite: 17 writes of 0..16, slot 0 now holds 16.
    do_reset();
    for (int unsigned i = 0; i < 17; i++) do_write(8'(i));
    chk_eq("wrap_occ", 32'(occupancy), 32'd16);
    chk_eq("wrap_cnt", 32'(wr_count),  32'd17);
    do_query(8'd0, 8'd16);
    chk_eq("wrap_rhit", 32'(r_hit), 32'h2);
    chk_eq("wrap_ridx", 32'(r_idx), 32'h00);
    do_query(8'd1, 8'd1);
    chk_eq("wrap_q1_rhit", 32'(r_hit), 32'h3);
    chk_eq("wrap_q1_ridx", 32'(r_idx), 32'h11);

    // Read-before-write and clear priority.
    do_reset();
    do_write(8'd10);
    wr_valid = 1'b1;
    wr_data  = 8'd99;
    q_valid  = 2'b11;
    q_data   = {8'd99, 8'd99};
    step();
    wr_valid = 1'b0;
    q_valid  = 2'b00;
    chk_eq("rbw_rvalid", 32'(r_valid), 32'h3);
    chk_eq("rbw_rhit",   32'(r_hit),   32'h0);
    do_query(8'd99, 8'd99);
    chk_eq("rbw_next_rhit", 32'(r_hit), 32'h3);
    chk_eq("rbw_next_ridx", 32'(r_idx), 32'h11);
    clear    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'd7;
    step();
    clear    = 1'b0;
    wr_valid = 1'b0;
    chk_eq("clr_occ",  32'(occupancy), 32'd0);
    chk_eq("clr_cnt",  32'(wr_count),  32'd2);
    chk_eq("clr_last", 32'(last_data), 32'd99);
    do_query(8'd7, 8'd99);
    chk_eq("clr_rhit", 32'(r_hit), 32'h0);
    do_write(8'd5);
    do_query(8'd5, 8'd5);
    chk_eq("clr_ptr_ridx", 32'(r_idx), 32'h00);
    chk_eq("clr_ptr_rhit", 32'(r_hit), 32'h3);

    // Duplicates: 42 in slots 2 and 9, lowest wins.
    do_reset();
    do_write(8'd1);
    do_write(8'd2);
    do_write(8'd42);
    for (int unsigned i = 3; i < 9; i++) do_write(8'(i));
    do_write(8'd42);
    do_query(8'd42, 8'd8);
    chk_eq("dup_rhit", 32'(r_hit), 32'h3);
    chk_eq("dup_ridx", 32'(r_idx), 32'h82);

    // Counter wrap, then reset discards an in-flight query.
    do_reset();
    for (int unsigned i = 0; i < 256; i++) do_write(8'(i));
    chk_eq("cw_cnt",  32'(wr_count),  32'd0);
    chk_eq("cw_occ",  32'(occupancy), 32'd16);
    chk_eq("cw_last", 32'(last_data), 32'd255);
    rst     = 1'b1;
    q_valid = 2'b11;
    q_data  = {8'd255, 8'd255};
    step();
    rst     = 1'b0;
    q_valid = 2'b00;
    chk_eq("rstq_rvalid", 32'(r_valid),   32'h0);
    chk_eq("rstq_rhit",   32'(r_hit),     32'h0);
    chk_eq("rstq_occ",    32'(occupancy), 32'd0);
    chk_eq("rstq_last",   32'(last_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
